// File: rtl/ysyx_22051145_idu_if.sv
// ysyx_22051145_idu_if: IFU/regfile/EXU facing signals of the decode stage
interface ysyx_22051145_idu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic        alu_en;
  logic [63:0] alu_pc;
  logic [63:0] alu_op1;
  logic [63:0] alu_op2;
  logic [3:0]  alu_mode;
  logic [4:0]  rd;
  logic        wen;
  logic        halt;
  logic        illegal;
  modport master (
    output in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, alu_en, alu_pc, alu_op1, alu_op2,
           alu_mode, rd, wen, halt, illegal
  );
  modport slave (
    input  in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, alu_en, alu_pc, alu_op1, alu_op2,
           alu_mode, rd, wen, halt, illegal
  );
endinterface

// File: rtl/ysyx_22051145_idu.sv
// ysyx_22051145_idu: RV64I integer-ALU decode stage with one output register slot and sticky halt
module ysyx_22051145_idu (
  input logic clk,
  input logic rst_n,
  ysyx_22051145_idu_if.slave bus
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] inst;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [5:0]  f6;
  logic        legal, ebreak, in_fire, out_fire, load, alt;
  logic [3:0]  mode;
  logic [63:0] op1, op2;
  logic        out_valid_q, illegal_q;
  assign inst     = bus.in_inst;
  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign f6       = inst[31:26];
  assign ebreak   = inst == 32'h0010_0073;
  assign bus.rs1_addr = inst[19:15];
  assign bus.rs2_addr = inst[24:20];
  assign bus.in_ready = (state == RUN) & (!out_valid_q | bus.out_ready);
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = out_valid_q & bus.out_ready;
  assign load     = in_fire & legal;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_en    = out_valid_q;
  assign bus.halt      = state == HALT;
  assign bus.illegal   = illegal_q;
  // funct3 selects the ALU op; alt picks SUB over ADD and SRA over SRL
  assign mode = f3 == 3'd0 ? {3'b001, alt} :
                f3 == 3'd5 ? {3'b100, alt} :
                f3 <  3'd5 ? {1'b0, f3} + 4'd3 : {1'b0, f3} + 4'd4;
  // operand selection and legality; EBREAK falls into the illegal default but is flagged separately
  always_comb begin
    legal = 1'b0;
    alt   = 1'b0;
    op1   = bus.rs1_data;
    op2   = bus.rs2_data;
    case (opc)
      7'b0110011: begin
        alt   = f7[5];
        legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'b0010011: begin
        alt   = f3 == 3'd5 && f6 == 6'h10;
        legal = f3 == 3'd1 ? f6 == 6'h00 : f3 == 3'd5 ? (f6 == 6'h00 || f6 == 6'h10) : 1'b1;
        op2   = (f3 == 3'd1 || f3 == 3'd5) ? {58'b0, inst[25:20]} : {{52{inst[31]}}, inst[31:20]};
      end
      7'b0110111, 7'b0010111: begin
        legal = 1'b1;
        op1   = 64'd0;
        op2   = {{32{inst[31]}}, inst[31:12], 12'b0};
      end
      default: ;
    endcase
  end
  // LUI/AUIPC bypass the funct3 mapping
  logic [3:0] mode_sel;
  assign mode_sel = opc == 7'b0110111 ? 4'd0 : opc == 7'b0010111 ? 4'd1 : mode;
  // RUN/HALT state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  // any accepted EBREAK or illegal word halts until reset
  always_comb begin
    state_nx = state;
    if (in_fire && !legal) state_nx = HALT;
  end
  // sticky illegal flag, not raised by EBREAK
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) illegal_q <= 1'b0;
    else if (in_fire && !legal && !ebreak) illegal_q <= 1'b1;
  // single output slot: load on legal accept, drain on consume
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      bus.alu_pc   <= 64'd0;
      bus.alu_op1  <= 64'd0;
      bus.alu_op2  <= 64'd0;
      bus.alu_mode <= 4'd0;
      bus.rd       <= 5'd0;
      bus.wen      <= 1'b0;
    end else if (load) begin
      out_valid_q  <= 1'b1;
      bus.alu_pc   <= bus.in_pc;
      bus.alu_op1  <= op1;
      bus.alu_op2  <= op2;
      bus.alu_mode <= mode_sel;
      bus.rd       <= inst[11:7];
      bus.wen      <= inst[11:7] != 5'd0;
    end else if (out_fire) out_valid_q <= 1'b0;
endmodule

// File: tb/tb_ysyx_22051145_idu.sv
// tb_ysyx_22051145_idu: directed vectors for the decode stage
module tb_ysyx_22051145_idu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  ysyx_22051145_idu_if bus();
  ysyx_22051145_idu dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input string tag, input logic [31:0] inst, input logic [63:0] pc,
                    input logic [63:0] r1, input logic [63:0] r2, input logic [3:0] m,
                    input logic [63:0] o1, input logic [63:0] o2, input logic [4:0] d, input logic w);
    bus.in_valid = 1'b1;
    bus.in_inst = inst;
    bus.in_pc = pc;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    bus.out_ready = 1'b1;
    #1 chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    tick;
    bus.in_valid = 1'b0;
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".alu_en"}, 64'(bus.alu_en), 64'd1);
    chk({tag, ".mode"}, 64'(bus.alu_mode), 64'(m));
    chk({tag, ".op1"}, bus.alu_op1, o1);
    chk({tag, ".op2"}, bus.alu_op2, o2);
    chk({tag, ".rd"}, 64'(bus.rd), 64'(d));
    chk({tag, ".wen"}, 64'(bus.wen), 64'(w));
    chk({tag, ".pc"}, bus.alu_pc, pc);
  endtask
  task automatic bad(input string tag, input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_inst = inst;
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk({tag, ".halt"}, 64'(bus.halt), 64'd1);
    chk({tag, ".illegal"}, 64'(bus.illegal), 64'd1);
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_inst = 32'd0;
    bus.in_pc = 64'd0;
    bus.rs1_data = 64'd0;
    bus.rs2_data = 64'd0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.alu_en", 64'(bus.alu_en), 64'd0);
    chk("rst.op2", bus.alu_op2, 64'd0);
    chk("rst.wen", 64'(bus.wen), 64'd0);
    chk("rst.halt", 64'(bus.halt), 64'd0);
    chk("rst.illegal", 64'(bus.illegal), 64'd0);
    rst_n = 1'b1;
    tick;
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    op("addi", 32'h0050_0093, 64'h8000_0000, 64'd0, 64'd0, 4'd2, 64'd0, 64'd5, 5'd1, 1'b1);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inst = 32'h8000_01B7;
    bus.in_pc = 64'h8000_0004;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.in_ready", 64'(bus.in_ready), 64'd0);
      tick;
      chk("bp.out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp.mode", 64'(bus.alu_mode), 64'd2);
      chk("bp.op2", bus.alu_op2, 64'd5);
      chk("bp.pc", bus.alu_pc, 64'h8000_0000);
    end
    op("lui", 32'h8000_01B7, 64'h8000_0004, 64'd0, 64'd0, 4'd0, 64'd0, 64'hFFFF_FFFF_8000_0000, 5'd3, 1'b1);
    bus.in_inst = 32'h4020_81B3;
    #1 chk("sub.rs1_addr", 64'(bus.rs1_addr), 64'd1);
    chk("sub.rs2_addr", 64'(bus.rs2_addr), 64'd2);
    op("sub", 32'h4020_81B3, 64'h8000_0008, 64'd7, 64'd2, 4'd3, 64'd7, 64'd2, 5'd3, 1'b1);
    op("srai", 32'h43F0_D293, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 64'd9, 4'd9, 64'hFFFF_FFFF_FFFF_FFF8, 64'd63, 5'd5, 1'b1);
    op("addi_x0", 32'hFFF1_0013, 64'h14, 64'd3, 64'd0, 4'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 1'b0);
    op("auipc", 32'h1234_5397, 64'h8000_1000, 64'd0, 64'd0, 4'd1, 64'd0, 64'h1234_5000, 5'd7, 1'b1);
    op("and", 32'h00C5_F533, 64'h18, 64'hF0F0, 64'h0FF0, 4'd11, 64'hF0F0, 64'h0FF0, 5'd10, 1'b1);
    op("sltiu", 32'h0011_B213, 64'h1C, 64'd5, 64'd0, 4'd6, 64'd5, 64'd1, 5'd4, 1'b1);
    tick;
    chk("drain.out_valid", 64'(bus.out_valid), 64'd0);
    chk("drain.hold_mode", 64'(bus.alu_mode), 64'd6);
    op("pre_ebreak", 32'h0050_0093, 64'h20, 64'd0, 64'd0, 4'd2, 64'd0, 64'd5, 5'd1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_inst = 32'h0010_0073;
    #1 chk("ebreak.in_ready", 64'(bus.in_ready), 64'd1);
    tick;
    chk("ebreak.halt", 64'(bus.halt), 64'd1);
    chk("ebreak.illegal", 64'(bus.illegal), 64'd0);
    chk("ebreak.out_valid", 64'(bus.out_valid), 64'd0);
    bus.in_inst = 32'h0050_0093;
    #1 chk("halted.in_ready", 64'(bus.in_ready), 64'd0);
    tick;
    chk("halted.out_valid", 64'(bus.out_valid), 64'd0);
    chk("halted.halt", 64'(bus.halt), 64'd1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk("rst_halt.halt", 64'(bus.halt), 64'd0);
    tick;
    rst_n = 1'b1;
    #1 chk("rst_halt.in_ready", 64'(bus.in_ready), 64'd1);
    bad("zero", 32'h0000_0000);
    bad("slli_f6", 32'h4020_9093);
    bad("sll_f7", 32'h4000_1033);
    bus.in_valid = 1'b1;
    bus.in_inst = 32'h0050_0093;
    bus.rs1_data = 64'd0;
    bus.out_ready = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    chk("rstbp.loaded", 64'(bus.out_valid), 64'd1);
    tick;
    rst_n = 1'b0;
    #1 chk("rstbp.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstbp.op2", bus.alu_op2, 64'd0);
    tick;
    rst_n = 1'b1;
    #1 chk("rstbp.in_ready", 64'(bus.in_ready), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22051145_idu.md
YSYX_22051145_IDU -- requirements
Module: ysyx_22051145_idu

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  input  1  IFU offers an instruction.
REQ-004 in_ready  output  1  IDU accepts the instruction this cycle.
REQ-005 in_inst  input  32  RV64 instruction word.
REQ-006 in_pc  input  64  PC of in_inst.
REQ-007 rs1_addr, rs2_addr  output  5 each  regfile read addresses, combinational inst[19:15], inst[24:20].
REQ-008 rs1_data, rs2_data  input  64 each  regfile read data, same cycle as address.
REQ-009 out_valid  output  1  registered decoded op present; also drives alu_en.
REQ-010 out_ready  input  1  EXU consumes the op this cycle.
REQ-011 alu_en  output  1  equal to out_valid.
REQ-012 alu_pc, alu_op1, alu_op2  output  64 each  registered ALU operands.
REQ-013 alu_mode  output  4  ALU operation code.
REQ-014 rd, wen  output  5, 1  destination register and write enable.
REQ-015 halt, illegal  output  1 each  sticky halt, sticky illegal-instruction flag.

Function
REQ-016 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-017 in_ready = (state==RUN) & (!out_valid | out_ready), combinational.
REQ-018 Latency 1: decoded op appears on outputs the cycle after input transfer.
REQ-019 Output registers load only on input transfer of a legal non-EBREAK instruction; otherwise hold.
REQ-020 out_valid: set on such transfer; cleared on output transfer with no simultaneous load; simultaneous output transfer and load keeps out_valid=1 with new data.
REQ-021 While out_valid & !out_ready all outputs stable (backpressure).
REQ-022 alu_mode map: LUI 0, AUIPC 1, ADD/ADDI 2, SUB 3, SLL/SLLI 4, SLT/SLTI 5, SLTU/SLTIU 6, XOR/XORI 7, SRL/SRLI 8, SRA/SRAI 9, OR/ORI 10, AND/ANDI 11.
REQ-023 OP (0110011): op1=rs1_data, op2=rs2_data; funct7 0x00 for all, 0x20 only for SUB/SRA.
REQ-024 OP-IMM (0010011): op1=rs1_data, op2=sext(inst[31:20]); shifts op2={58'b0,inst[25:20]}, inst[31:26] 0x00 (SLLI/SRLI) or 0x10 (SRAI).
REQ-025 LUI (0110111)/AUIPC (0010111): op1=0, op2=sext({inst[31:12],12'b0}) to 64.
REQ-026 alu_pc=in_pc for every op; rd=inst[11:7]; wen=1 for legal ops with rd!=0, else 0.
REQ-027 FSM states RUN, HALT; RUN->HALT on input transfer of EBREAK (0x00100073) or any illegal encoding; HALT exits only on reset.
REQ-028 EBREAK sets halt=1; illegal sets halt=1 and illegal=1; neither produces out_valid.
REQ-029 Halting instruction does not discard a pending output op; it drains normally via out_ready.
REQ-030 Any opcode/funct combination not listed in REQ-022..025 is illegal.

Reset
REQ-031 rst_n low: state=RUN, out_valid=0, alu_en=0, all operand/mode/rd/wen=0, halt=0, illegal=0, immediately (async).
REQ-032 Reset mid-backpressure discards pending op; first cycle after release in_ready=1.

Verification
REQ-033 in_inst=0x00500093, in_pc=0x80000000, rs1_data=0 -> next cycle out_valid=1, mode=2, op1=0, op2=5, rd=1, wen=1.
REQ-034 in_inst=0x800001B7 -> mode=0, op1=0, op2=0xFFFFFFFF80000000, rd=3, wen=1.
REQ-035 in_inst=0x402081B3, rs1_data=7, rs2_data=2 -> rs1_addr=1, rs2_addr=2; mode=3, op1=7, op2=2, rd=3.
REQ-036 valid op held with out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, outputs unchanged; out_ready=1 -> next op loaded same edge, out_valid stays 1.
REQ-037 in_inst=0x00100073 -> halt=1, illegal=0, in_ready=0 thereafter, no out_valid; rst_n pulse -> halt=0, in_ready=1.
REQ-038 in_inst=0x00000000 -> halt=1, illegal=1; in_inst=0x40209093 (SLLI bad funct6) -> illegal=1.
